// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin arbiter and its request shaper.
package arb_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned LEN_W   = 4;
   localparam int unsigned QDEPTH  = 2;

   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

   localparam int unsigned REQ0 = 0;
   localparam int unsigned REQ1 = 1;
   localparam int unsigned REQ2 = 2;
   localparam int unsigned REQ3 = 3;

   localparam logic [NUM_REQ-1:0] GNT_REQ0 = 4'b0001;
   localparam logic [NUM_REQ-1:0] GNT_REQ1 = 4'b0010;
   localparam logic [NUM_REQ-1:0] GNT_REQ2 = 4'b0100;
   localparam logic [NUM_REQ-1:0] GNT_REQ3 = 4'b1000;

   typedef logic [LEN_W-1:0] len_t;
   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/arb_req_lane.sv
// One requester lane: burst-length FIFO feeding a remaining-beat counter that drives REQ.
module arb_req_lane
   import arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic push_valid,
   input  len_t push_len,
   output logic push_ready,
   input  logic gnt,
   output logic req,
   output logic beat_done,
   output logic burst_done,
   output logic spurious
);

   len_t mem [QDEPTH];
   ptr_t rd_ptr, rd_ptr_nxt;
   ptr_t wr_ptr, wr_ptr_nxt;
   cnt_t count, count_nxt;
   len_t rem, rem_nxt;
   logic fifo_wr;
   logic fifo_rd;

   assign push_ready = (count != CNT_W'(QDEPTH));
   assign req        = (rem != '0) || (count != '0);

   // Next-state: a load on the final granted beat chains bursts without a bubble.
   always_comb begin
      fifo_wr    = 1'b0;
      fifo_rd    = 1'b0;
      rem_nxt    = rem;
      count_nxt  = count;
      rd_ptr_nxt = rd_ptr;
      wr_ptr_nxt = wr_ptr;
      beat_done  = 1'b0;
      burst_done = 1'b0;
      spurious   = 1'b0;

      fifo_wr = push_valid && push_ready && (push_len != '0);
      fifo_rd = ((rem == '0) || ((rem == LEN_W'(1)) && gnt)) && (count != '0);

      if (!rst) begin
         beat_done  = gnt && (rem != '0);
         burst_done = gnt && (rem == LEN_W'(1));
         spurious   = gnt && (rem == '0);
      end

      if (fifo_rd) begin
         rem_nxt    = mem[rd_ptr];
         rd_ptr_nxt = rd_ptr + PTR_W'(1);
      end else if (gnt && (rem != '0)) begin
         rem_nxt = rem - LEN_W'(1);
      end

      if (fifo_wr) begin
         wr_ptr_nxt = wr_ptr + PTR_W'(1);
      end

      count_nxt = count + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem    <= '0;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         rem    <= rem_nxt;
         count  <= count_nxt;
         rd_ptr <= rd_ptr_nxt;
         wr_ptr <= wr_ptr_nxt;
      end
   end

   // Storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (!rst && fifo_wr) begin
         mem[wr_ptr] <= push_len;
      end
   end

endmodule

// File: rtl/arb_req_shaper.sv
// Request shaper in front of the 4-way arbiter: per-lane burst tracking plus grant protocol checks.
module arb_req_shaper
   import arb_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       push_valid,
   input  logic [NUM_REQ*LEN_W-1:0] push_len,
   output logic [NUM_REQ-1:0]       push_ready,
   input  logic [NUM_REQ-1:0]       GNT,
   output logic [NUM_REQ-1:0]       REQ,
   output logic [NUM_REQ-1:0]       beat_done,
   output logic [NUM_REQ-1:0]       burst_done,
   output logic                     spurious_gnt,
   output logic                     gnt_err
);

   logic [NUM_REQ-1:0] spurious;
   logic               multi_gnt;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      arb_req_lane u_lane (
         .clk        (clk),
         .rst        (rst),
         .push_valid (push_valid[i]),
         .push_len   (push_len[i*LEN_W +: LEN_W]),
         .push_ready (push_ready[i]),
         .gnt        (GNT[i]),
         .req        (REQ[i]),
         .beat_done  (beat_done[i]),
         .burst_done (burst_done[i]),
         .spurious   (spurious[i])
      );
   end

   assign spurious_gnt = |spurious;

   // More than one bit set iff clearing the lowest set bit leaves something.
   assign multi_gnt = (GNT & (GNT - NUM_REQ'(1))) != '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_err <= 1'b0;
      end else if (multi_gnt) begin
         gnt_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_arb_req_shaper.sv
// Bench for arb_req_shaper: directed scenarios then random traffic, checked against a queue-based model.
module tb_arb_req_shaper;
   import arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  push_valid;
   logic [15:0] push_len;
   logic [3:0]  push_ready;
   logic [3:0]  GNT;
   logic [3:0]  REQ;
   logic [3:0]  beat_done;
   logic [3:0]  burst_done;
   logic        spurious_gnt;
   logic        gnt_err;

   int   q_m [NUM_REQ][$];
   int   rem_m [NUM_REQ];
   logic err_m;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   arb_req_shaper dut (
      .clk          (clk),
      .rst          (rst),
      .push_valid   (push_valid),
      .push_len     (push_len),
      .push_ready   (push_ready),
      .GNT          (GNT),
      .REQ          (REQ),
      .beat_done    (beat_done),
      .burst_done   (burst_done),
      .spurious_gnt (spurious_gnt),
      .gnt_err      (gnt_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] lens(input int l0, input int l1, input int l2, input int l3);
      return {4'(l3), 4'(l2), 4'(l1), 4'(l0)};
   endfunction

   // One clock cycle: drive, check mid-cycle outputs against the model, then advance the model.
   task automatic step(input logic r, input logic [3:0] pv, input logic [15:0] pl, input logic [3:0] g);
      logic [3:0] e_ready, e_req, e_beat, e_burst;
      logic       e_spur;
      int         sz;
      int         len;
      logic       load;
      rst        = r;
      push_valid = pv;
      push_len   = pl;
      GNT        = g;
      @(negedge clk);
      e_spur = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sz         = q_m[i].size();
         e_ready[i] = (sz != QDEPTH);
         e_req[i]   = (rem_m[i] != 0) || (sz != 0);
         e_beat[i]  = !r && g[i] && (rem_m[i] != 0);
         e_burst[i] = !r && g[i] && (rem_m[i] == 1);
         if (!r && g[i] && (rem_m[i] == 0)) e_spur = 1'b1;
      end
      chk("push_ready", 32'(push_ready), 32'(e_ready));
      chk("REQ", 32'(REQ), 32'(e_req));
      chk("beat_done", 32'(beat_done), 32'(e_beat));
      chk("burst_done", 32'(burst_done), 32'(e_burst));
      chk("spurious_gnt", 32'(spurious_gnt), 32'(e_spur));
      chk("gnt_err", 32'(gnt_err), 32'(err_m));
      @(posedge clk);
      #1;
      if (r) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            q_m[i].delete();
            rem_m[i] = 0;
         end
         err_m = 1'b0;
      end else begin
         if ($countones(g) > 1) err_m = 1'b1;
         for (int i = 0; i < NUM_REQ; i++) begin
            sz   = q_m[i].size();
            len  = int'(pl[i*4 +: 4]);
            load = ((rem_m[i] == 0) || ((rem_m[i] == 1) && g[i])) && (sz != 0);
            if (load) rem_m[i] = q_m[i].pop_front();
            else if (g[i] && (rem_m[i] != 0)) rem_m[i] = rem_m[i] - 1;
            if (pv[i] && (sz != QDEPTH) && (len != 0)) q_m[i].push_back(len);
         end
      end
   endtask

   initial begin
      logic [3:0]  rg;
      logic [3:0]  rpv;
      logic [15:0] rpl;
      int          sel;

      for (int i = 0; i < NUM_REQ; i++) rem_m[i] = 0;
      err_m      = 1'b0;
      rst        = 1'b1;
      push_valid = '0;
      push_len   = '0;
      GNT        = '0;
      repeat (2) @(posedge clk);
      #1;
      step(1'b1, 4'b0000, 16'h0, 4'b0000);
      chk("reset_req", 32'(REQ), 32'h0);
      chk("reset_ready", 32'(push_ready), 32'hF);

      // Reset in the middle of a burst.
      step(1'b0, 4'b0001, lens(5, 0, 0, 0), 4'b0000);
      step(1'b0, 4'b0000, 16'h0, 4'b0000);
      step(1'b0, 4'b0000, 16'h0, GNT_REQ0);
      step(1'b0, 4'b0000, 16'h0, GNT_REQ0);
      step(1'b1, 4'b0000, 16'h0, GNT_REQ0);
      chk("midburst_rst_req", 32'(REQ), 32'h0);
      chk("midburst_rst_ready", 32'(push_ready), 32'hF);
      chk("midburst_rst_err", 32'(gnt_err), 32'h0);

      // Single burst of 3, grant held one cycle past the end.
      step(1'b0, 4'b0010, lens(0, 3, 0, 0), 4'b0000);
      step(1'b0, 4'b0000, 16'h0, 4'b0000);
      repeat (4) step(1'b0, 4'b0000, 16'h0, GNT_REQ1);
      step(1'b0, 4'b0000, 16'h0, 4'b0000);

      // Back-to-back bursts on lane 2.
      step(1'b0, 4'b0100, lens(0, 0, 2, 0), 4'b0000);
      step(1'b0, 4'b0100, lens(0, 0, 1, 0), 4'b0000);
      repeat (3) step(1'b0, 4'b0000, 16'h0, GNT_REQ2);
      step(1'b0, 4'b0000, 16'h0, 4'b0000);
      chk("b2b_req_idle", 32'(REQ), 32'h0);

      // Fill lane 3 and hold off a fourth push until a burst completes.
      step(1'b0, 4'b1000, lens(0, 0, 0, 1), 4'b0000);
      step(1'b0, 4'b1000, lens(0, 0, 0, 2), 4'b0000);
      step(1'b0, 4'b1000, lens(0, 0, 0, 3), 4'b0000);
      step(1'b0, 4'b1000, lens(0, 0, 0, 4), 4'b0000);
      chk("full_ready", 32'(push_ready), 32'h7);
      step(1'b0, 4'b1000, lens(0, 0, 0, 4), GNT_REQ3);
      step(1'b0, 4'b1000, lens(0, 0, 0, 4), GNT_REQ3);
      repeat (10) step(1'b0, 4'b0000, 16'h0, GNT_REQ3);
      step(1'b0, 4'b0000, 16'h0, 4'b0000);

      // Zero-length push and an illegal multi-hot grant.
      step(1'b0, 4'b0001, lens(0, 0, 0, 0), 4'b0000);
      step(1'b0, 4'b0000, 16'h0, 4'b0000);
      chk("zero_len_req", 32'(REQ), 32'h0);
      step(1'b0, 4'b0000, 16'h0, 4'b0011);
      repeat (3) step(1'b0, 4'b0000, 16'h0, 4'b0000);
      chk("gnt_err_sticky", 32'(gnt_err), 32'h1);
      step(1'b1, 4'b0000, 16'h0, 4'b0000);
      chk("gnt_err_cleared", 32'(gnt_err), 32'h0);

      // Full round-robin pass over all lanes.
      step(1'b0, 4'b1111, lens(3, 3, 3, 3), 4'b0000);
      step(1'b0, 4'b0000, 16'h0, 4'b0000);
      for (int l = 0; l < NUM_REQ; l++) begin
         repeat (3) step(1'b0, 4'b0000, 16'h0, 4'(1 << l));
      end
      step(1'b0, 4'b0000, 16'h0, 4'b0000);
      chk("round_req_idle", 32'(REQ), 32'h0);

      // Random traffic, mostly legal grants with occasional multi-hot and reset.
      repeat (800) begin
         rpv = 4'($urandom);
         rpl = '0;
         for (int i = 0; i < NUM_REQ; i++) rpl[i*4 +: 4] = 4'($urandom_range(0, 4));
         sel = int'($urandom_range(0, 9));
         if (sel < 2) rg = 4'b0000;
         else if (sel < 9) rg = 4'(1 << $urandom_range(0, 3));
         else rg = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 63) == 0), rpv, rpl, rg);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/arb_req_shaper.md
Name: arb_req_shaper

Overview:
- Upstream feeder for the 4-way round-robin time-slice arbiter.
- Each requester pushes burst lengths (in beats) into a small per-requester FIFO. The block drives REQ[i] while requester i has beats outstanding.
- Each cycle with GNT[i] high consumes one beat.
- Flags grant protocol anomalies (spurious or non-one-hot grants) so the arbiter stage can be checked in-system.

Parameters:
- NUM_REQ, 4, number of requesters (fixed to the arbiter width).
- LEN_W, 4, width of a burst length field; max burst is 2^LEN_W-1 beats.
- QDEPTH, 2, burst FIFO entries per requester (power of 2, >=2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- push_valid  in  NUM_REQ  per-requester burst push strobe.
- push_len  in  NUM_REQ*LEN_W  burst length; requester i occupies bits [i*LEN_W +: LEN_W].
- push_ready  out  NUM_REQ  FIFO i not full.
- GNT  in  NUM_REQ  grant vector from the arbiter (registered there; one-hot or zero).
- REQ  out  NUM_REQ  request vector to the arbiter.
- beat_done  out  NUM_REQ  pulse: one beat of requester i consumed this cycle.
- burst_done  out  NUM_REQ  pulse: last beat of the active burst of requester i consumed this cycle.
- spurious_gnt  out  1  pulse: GNT[i] high while requester i has no active beats.
- gnt_err  out  1  sticky: GNT observed with more than one bit set.

Behaviour:
- Reset: all FIFOs empty, all remaining counters 0, REQ=0, push_ready=all ones, beat_done=0, burst_done=0, spurious_gnt=0, gnt_err=0.
- Everything is synchronous to clk. rst overrides all other inputs in the same cycle and aborts in-flight bursts with no done pulses.
- Per-lane state: FIFO (QDEPTH x LEN_W) with a count, and a remaining counter rem (LEN_W bits).
- Push:
  - Accepted when push_valid[i] && push_ready[i].
  - push_ready[i] = fifo count != QDEPTH, computed from registered state only; a same-cycle pop does not raise it.
  - A push with len 0 is accepted and discarded: no FIFO write and no REQ effect.
- REQ[i] = (rem != 0) || (fifo count != 0), decoded from registers. Latency: push accepted at edge N gives REQ high in the cycle after edge N.
- Consume: in a cycle where GNT[i] && rem != 0, rem decrements by 1 at the next edge and beat_done[i] pulses combinationally in that cycle.
  - If rem == 1 in that cycle, burst_done[i] pulses too.
- Load:
  - Condition: (rem == 0, or rem == 1 && GNT[i]) && fifo count != 0.
  - At the next edge: rem takes the FIFO head and the FIFO pops. Back-to-back bursts therefore have no bubble.
  - A push into an empty FIFO is not bypassed; it loads one cycle later.
- Simultaneous push and pop on the same lane: both happen and the count is unchanged. When the lane is full, push_ready=0, so the push is refused.
- Spurious grant: GNT[i] && rem == 0, including the extra grant cycle the arbiter issues after REQ drops because of its registered GNT.
  - spurious_gnt pulses that cycle; no state change.
  - The grant still counts if the same cycle loads a new burst, since rem is 0.
- gnt_err: set when $countones(GNT) > 1; cleared only by rst. The lanes still process each granted bit independently.
- Counters never wrap: rem cannot underflow, because the decrement is gated by rem != 0.

Decomposition:
- Shared package arb_pkg holds:
  - NUM_REQ, LEN_W and QDEPTH defaults.
  - Lane index constants REQ0..REQ3 and their one-hot grant encodings 4'b0001, 4'b0010, 4'b0100, 4'b1000, shared with the arbiter.
  - Typedef len_t for logic [LEN_W-1:0].
- One natural sub-module, arb_req_lane: FIFO, rem counter, push_ready/REQ/beat_done/burst_done for one requester. Instantiate it NUM_REQ times.
- The top level handles lane slicing, spurious_gnt OR-reduction and gnt_err.

Test Plan:
- Reset mid-burst: push len 5 on lane 0, grant 2 cycles, assert rst 1 cycle -> REQ=0000, push_ready=1111, gnt_err=0, no burst_done pulse.
- Single burst: push len 3 on lane 1, then GNT=0010 held -> REQ[1] high one cycle after the push; beat_done[1] pulses 3 times; burst_done[1] pulses on the 3rd; REQ[1] drops the next cycle; a 4th GNT cycle gives spurious_gnt=1.
- Back-to-back: push len 2 then len 1 on lane 2, GNT=0100 continuous -> 3 consecutive beat_done pulses, burst_done on beats 2 and 3, REQ[2] never drops in between.
- FIFO full: with GNT=0, push 3 bursts on lane 3 -> 1st loads into rem, 2nd and 3rd fill the FIFO, push_ready[3]=0; a 4th push is held off until the first GNT beat completes a burst.
- Zero length and illegal grant: push len 0 on lane 0 -> REQ[0] stays 0; drive GNT=0011 -> gnt_err=1 and stays 1 until rst.
- Full round: bursts of 3 beats on all lanes, GNT rotating 0001/0010/0100/1000 for 3 cycles each -> 4 burst_done pulses in lane order, REQ=0000 at the end, spurious_gnt never asserted.
